// File: rtl/reg_file_pkg.sv
// Shared register-file constants, also consumed by the ALU and the decoder.
// x0 is hard-wired to zero and is addressed by REG_ZERO.
package reg_file_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned REG_ZERO = 0;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // A write only lands when enabled and not aimed at x0.
  function automatic logic is_reg_write(input logic we, input logic is_zero_idx);
    return we && !is_zero_idx;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: index decode, x0 forcing and, when
// REG_FILE_BYPASS_EN is defined, write-through forwarding of the pending write.
module reg_file_read_port #(
  parameter int unsigned XLEN   = reg_file_pkg::XLEN,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]                 rs,
  input  logic [(2**ADDR_W)-1:0][XLEN-1:0]  regs,
`ifdef REG_FILE_BYPASS_EN
  input  logic                              reset,
  input  logic                              we,
  input  logic [ADDR_W-1:0]                 rd,
  input  logic [XLEN-1:0]                   wd,
`endif
  output logic [XLEN-1:0]                   rdata
);

  import reg_file_pkg::*;

  logic rs_is_zero;

  assign rs_is_zero = (rs == ADDR_W'(REG_ZERO));

`ifdef REG_FILE_BYPASS_EN
  logic fwd_hit;

  // Forwarding is suppressed under reset so the ports read the cleared file.
  assign fwd_hit = !reset && is_reg_write(we, rd == ADDR_W'(REG_ZERO)) && (rs == rd);
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = regs[rs];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_hit) rdata = wd;
`endif
    if (rs_is_zero) rdata = '0;
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: 2**ADDR_W x XLEN, two combinational read ports, one
// synchronous write port, x0 reads zero. Define REG_FILE_BYPASS_EN for write-through.
module reg_file #(
  parameter int unsigned XLEN   = reg_file_pkg::XLEN,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   wd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  import reg_file_pkg::*;

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       wr_en;

  assign wr_en = is_reg_write(we, rd == ADDR_W'(REG_ZERO));

  // NOTE: the storage array is reset deliberately; the whole file must read
  // zero after reset, and reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (wr_en) begin
      regs[rd] <= wd;
    end
  end

  reg_file_read_port #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .rs    (rs1),
    .regs  (regs),
`ifdef REG_FILE_BYPASS_EN
    .reset (reset),
    .we    (we),
    .rd    (rd),
    .wd    (wd),
`endif
    .rdata (rd1)
  );

  reg_file_read_port #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .rs    (rs2),
    .regs  (regs),
`ifdef REG_FILE_BYPASS_EN
    .reset (reset),
    .we    (we),
    .rd    (rd),
    .wd    (wd),
`endif
    .rdata (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array reference model compared on every
// negedge, directed literal checks, then randomized traffic with sporadic resets.
module tb_reg_file;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   wd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] model [NREGS];
  bit              armed = 1'b0;
  bit              bypass_build;

  reg_file #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .rd    (rd),
    .wd    (wd),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: what a read index must return this cycle, from the rules alone.
  function automatic logic [XLEN-1:0] expect_read(input logic [ADDR_W-1:0] rs);
    if (rs == 0) return '0;
    if (bypass_build && we && !reset && rd != 0 && rs == rd) return wd;
    return model[rs];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      armed = 1'b1;
    end else if (we && rd != 0) begin
      model[rd] = wd;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_rd1", rd1, expect_read(rs1));
      check("model_rd2", rd2, expect_read(rs2));
    end
  end

  task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] d,
                       input logic [XLEN-1:0] data, input logic [ADDR_W-1:0] s1,
                       input logic [ADDR_W-1:0] s2);
    @(posedge clk);
    #1;
    reset = r; we = w; rd = d; wd = data; rs1 = s1; rs2 = s2;
  endtask

  initial begin
`ifdef REG_FILE_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
    reset = 1'b1; we = 1'b1; rd = 5'd3; wd = 32'h55; rs1 = '0; rs2 = '0;

    // Reset edge coinciding with a write to x3, then a write-heavy reset cycle.
    drive(1'b1, 1'b1, 5'd9, 32'hCAFE_0009, 5'd3, 5'd9);
    @(negedge clk);
    check("reset_x3", rd1, 32'h0);
    check("reset_x9", rd2, 32'h0);

    // Every index reads zero after reset on both ports.
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(NREGS - 1 - i));
      @(negedge clk);
      check("clear_rd1", rd1, 32'h0);
      check("clear_rd2", rd2, 32'h0);
    end

    // First write after reset deassertion lands normally.
    drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clk);
    check("post_reset_x3", rd1, 32'h55);

    // x5 write, then a we=0 cycle aimed at x5 must not change it.
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd5, 32'h1, 5'd5, 5'd5);
    @(negedge clk);
    check("x5_rd1", rd1, 32'hDEAD_BEEF);
    check("x5_rd2", rd2, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    check("x5_kept", rd1, 32'hDEAD_BEEF);

    // Writes to x0 are discarded and never forwarded.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    @(negedge clk);
    check("x0_same_cycle", rd1, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    check("x0_after", rd1, 32'h0);

    // Same-cycle read of the register being written.
    drive(1'b0, 1'b1, 5'd7, 32'hA, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0);
    @(negedge clk);
    check("x7_same_cycle", rd1, bypass_build ? 32'h1234_5678 : 32'h0000_000A);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(negedge clk);
    check("x7_next_cycle", rd1, 32'h1234_5678);

    // Boundary indices.
    drive(1'b0, 1'b1, 5'd31, 32'h8000_0000, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd1, 32'h7FFF_FFFF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    @(negedge clk);
    check("x31", rd1, 32'h8000_0000);
    check("x1", rd2, 32'h7FFF_FFFF);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic              r, w;
      logic [ADDR_W-1:0] d, s1, s2;
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 3) != 0);
      d  = ADDR_W'($urandom);
      s1 = ($urandom_range(0, 3) == 0) ? d : ADDR_W'($urandom);
      s2 = ($urandom_range(0, 4) == 0) ? s1 : ADDR_W'($urandom);
      drive(r, w, d, $urandom, s1, s2);
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, meaning data width of every register and port.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, meaning register index width (2**ADDR_W registers).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port we  input  1  write enable for the write port.
REQ-006 The block SHALL have port rd  input  ADDR_W  destination register index.
REQ-007 The block SHALL have port wd  input  XLEN  write data.
REQ-008 The block SHALL have port rs1  input  ADDR_W  read port 1 index.
REQ-009 The block SHALL have port rs2  input  ADDR_W  read port 2 index.
REQ-010 The block SHALL have port rd1  output  XLEN  read port 1 data, driving the ALU in1 operand path.
REQ-011 The block SHALL have port rd2  output  XLEN  read port 2 data, driving the ALU in2 operand path.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of XLEN bits; index 0 is x0.
REQ-013 Reads SHALL be combinational: rd1/rd2 reflect the addressed register in the same cycle rs1/rs2 change, zero cycles latency.
REQ-014 Writes SHALL be synchronous: with we=1 and rd!=0, register[rd] takes wd at the rising clk edge; visible on the read ports from the following cycle (without bypass).
REQ-015 x0 SHALL always read 0; writes with rd=0 SHALL be discarded regardless of we or wd.
REQ-016 With we=0 no register SHALL change.
REQ-017 rs1==rs2 SHALL return identical data on both ports.
REQ-018 Exactly one write per cycle; reads and write to different indices in the same cycle SHALL not interact.
REQ-019 Out-of-range values are impossible by width; all 2**ADDR_W indices SHALL be valid, none producing X.

Reset
REQ-020 reset=1 at a rising clk edge SHALL clear all registers to 0, taking priority over a simultaneous write.
REQ-021 While reset is held, rd1 and rd2 SHALL read 0 from the cycle after the first reset edge onward.
REQ-022 Reset asserted during a write-heavy sequence SHALL leave no partially written register; the first write after reset deassertion SHALL behave per REQ-014.

Configuration
REQ-023 Macro REG_FILE_BYPASS_EN SHALL enable write-through forwarding.
REQ-024 With REG_FILE_BYPASS_EN defined: when we=1, rd!=0, reset=0 and rsN==rd, rdN SHALL output wd in the same cycle (before the edge).
REQ-025 With REG_FILE_BYPASS_EN undefined: rdN SHALL output the stored (old) value in that case; the new value appears the next cycle.
REQ-026 Bypass SHALL never forward for rd=0 or while reset=1; x0 still reads 0.

Structure
REQ-027 A shared package SHALL hold XLEN, ADDR_W and the x0 index constant REG_ZERO, also used by the ALU and decoder.
REQ-028 One sub-module reg_file_read_port (index decode, x0 forcing, optional bypass mux) SHALL be instantiated twice, once per read port.
REQ-029 Storage and write logic SHALL reside in reg_file itself.

Verification
REQ-030 Reset then read all 32 indices on both ports -> every read returns 0x00000000.
REQ-031 Write 0xDEADBEEF to x5 (we=1), next cycle rs1=5, rs2=5 -> rd1=rd2=0xDEADBEEF; with we=0 and wd=0x1 on rd=5 the next cycle, x5 still 0xDEADBEEF.
REQ-032 Write 0xFFFFFFFF to x0, then rs1=0 -> rd1=0x00000000.
REQ-033 Same cycle: we=1, rd=7, wd=0x12345678, rs1=7, x7 previously 0xA -> rd1=0x12345678 with REG_FILE_BYPASS_EN, 0x0000000A without; next cycle 0x12345678 in both builds.
REQ-034 Same edge: reset=1 and we=1, rd=3, wd=0x55 -> x3 reads 0 afterwards; first write after deassertion lands normally.
REQ-035 Write x31=0x80000000 and x1=0x7FFFFFFF, read rs1=31, rs2=1 -> rd1=0x80000000, rd2=0x7FFFFFFF, boundary indices correct.
